// File: rtl/pipelined_wide_reduce.sv
// pipelined_wide_reduce
//   Two-stage reducer for a WIDTH-bit vector. The operator is selected at
//   run time (OR, AND, XOR, NOR) and travels down the pipe with its data.
//   Stage 1 reduces each CHUNK-bit slice to one partial bit. Stage 2 reduces
//   the partials and registers the result. Latency is 2 cycles, and the pipe
//   accepts one vector per cycle.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    qualifies in_data / in_mode
//   in_data     WIDTH-bit vector to reduce
//   in_mode     00=OR 01=AND 10=XOR 11=NOR
//   sticky_clr  clears sticky_hit and hit_count (a hit in the same cycle wins)
//   out_valid   result valid, 2 cycles after in_valid
//   out_result  reduced result (holds while out_valid=0)
//   out_chunks  per-slice partials of the result (OR partials for NOR)
//   sticky_hit  set by any valid result of 1 since the last clear
//   hit_count   saturating count of valid results equal to 1
module pipelined_wide_reduce #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 12,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned NCH  = (WIDTH + CHUNK - 1) / CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             sticky_clr,
  output logic             out_valid,
  output logic             out_result,
  output logic [NCH-1:0]   out_chunks,
  output logic             sticky_hit,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned PADW = NCH * CHUNK;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  mode_e            mode_in;
  logic [PADW-1:0]  padded;
  logic [CHUNK-1:0] slice;
  logic [NCH-1:0]   part;

  logic             s1_valid;
  mode_e            s1_mode;
  logic [NCH-1:0]   s1_part;

  logic             final_bit;
  logic             hit;

  assign mode_in = mode_e'(in_mode);

  // Stage 1: the bits above WIDTH are filled with the operator identity.
  // That fill is 1 for AND and 0 for every other mode, so the padding never
  // changes the result.
  always_comb begin
    padded              = {PADW{mode_in == MODE_AND}};
    padded[WIDTH-1:0]   = in_data;
    slice               = '0;
    part                = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      slice = padded[k*CHUNK +: CHUNK];
      case (mode_in)
        MODE_AND: part[k] = &slice;
        MODE_XOR: part[k] = ^slice;
        default:  part[k] = |slice;   // OR and NOR both use OR partials
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_OR;
      s1_part  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_mode  <= mode_in;
      s1_part  <= part;
    end
  end

  // Stage 2: combine the partials. With NCH=1 this passes the single
  // partial through, and NOR still inverts it.
  always_comb begin
    case (s1_mode)
      MODE_AND: final_bit = &s1_part;
      MODE_XOR: final_bit = ^s1_part;
      MODE_NOR: final_bit = ~|s1_part;
      default:  final_bit = |s1_part;
    endcase
  end

  assign hit = s1_valid & final_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 1'b0;
      out_chunks <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= final_bit;
        out_chunks <= s1_part;
      end
    end
  end

  // A clear and a hit in the same cycle behave as clear-then-set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_hit <= 1'b0;
      hit_count  <= '0;
    end else if (sticky_clr) begin
      sticky_hit <= hit;
      hit_count  <= CNT_W'(hit);
    end else if (hit) begin
      sticky_hit <= 1'b1;
      if (hit_count != '1) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_wide_reduce.sv
module tb_pipelined_wide_reduce;

  localparam logic [1:0] M_OR  = 2'b00;
  localparam logic [1:0] M_AND = 2'b01;
  localparam logic [1:0] M_XOR = 2'b10;
  localparam logic [1:0] M_NOR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [1:0]  in_mode;
  logic        sticky_clr;

  logic        ov1, res1, st1;
  logic [5:0]  ch1;
  logic [15:0] cnt1;
  logic        ov2, res2, st2;
  logic [5:0]  ch2;
  logic [1:0]  cnt2;

  pipelined_wide_reduce #(.WIDTH(64), .CHUNK(12), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .sticky_clr(sticky_clr), .out_valid(ov1),
    .out_result(res1), .out_chunks(ch1), .sticky_hit(st1), .hit_count(cnt1)
  );

  pipelined_wide_reduce #(.WIDTH(64), .CHUNK(12), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .sticky_clr(sticky_clr), .out_valid(ov2),
    .out_result(res2), .out_chunks(ch2), .sticky_hit(st2), .hit_count(cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        res;
    logic [5:0]  ch;
    logic        sticky;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    int          at;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one valid vector. The expectation is queued only when push=1.
  task automatic issue(input logic [1:0] m, input logic [63:0] d, input logic clr,
                       input logic push, input logic r, input logic [5:0] ch,
                       input logic s, input logic [15:0] c, input logic [1:0] c2);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    in_mode    = m;
    in_data    = d;
    sticky_clr = clr;
    if (push) q.push_back('{r, ch, s, c, c2, cyc + 2});
  endtask

  task automatic idle(input logic clr);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_data    = '0;
    sticky_clr = clr;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results missing expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: every presented result must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ov1 || ov2) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", {62'd0, ov1, ov2}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("valid",      {62'd0, ov1, ov2}, 64'd3);
        chk("latency",    64'(cyc),  64'(e.at));
        chk("result",     64'(res1), 64'(e.res));
        chk("chunks",     64'(ch1),  64'(e.ch));
        chk("sticky",     64'(st1),  64'(e.sticky));
        chk("count",      64'(cnt1), 64'(e.cnt));
        chk("sat_result", 64'(res2), 64'(e.res));
        chk("sat_chunks", 64'(ch2),  64'(e.ch));
        chk("sat_sticky", 64'(st2),  64'(e.sticky));
        chk("sat_count",  64'(cnt2), 64'(e.cnt2));
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  64'(ov1),  64'd0);
    chk({tag, "_result"}, 64'(res1), 64'd0);
    chk({tag, "_chunks"}, 64'(ch1),  64'd0);
    chk({tag, "_sticky"}, 64'(st1),  64'd0);
    chk({tag, "_count"},  64'(cnt1), 64'd0);
    chk({tag, "_sat_count"}, 64'(cnt2), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = M_OR; sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // 1: OR, then bit 63 lands in the padded top slice
    issue(M_OR, 64'd0,              0, 1, 0, 6'b000000, 0, 0, 0);
    issue(M_OR, 64'h8000_0000_0000_0000, 0, 1, 1, 6'b100000, 1, 1, 1);
    idle(0); drain();

    // 2: AND, padding must be ones
    issue(M_AND, '1,                     0, 1, 1, 6'b111111, 1, 2, 2);
    issue(M_AND, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 6'b111110, 1, 2, 2);
    idle(0); drain();

    // 3: mode changes every cycle
    issue(M_OR,  64'h3, 0, 1, 1, 6'b000001, 1, 3, 3);
    issue(M_XOR, 64'h3, 0, 1, 0, 6'b000000, 1, 3, 3);
    issue(M_NOR, 64'h3, 0, 1, 0, 6'b000001, 1, 3, 3);
    issue(M_AND, 64'h3, 0, 1, 0, 6'b000000, 1, 3, 3);
    idle(0); drain();

    // 4: clear alone, three hits, clear together with a fourth hit, non-hit
    idle(1);
    issue(M_OR, 64'h1, 0, 1, 1, 6'b000001, 1, 1, 1);
    issue(M_OR, 64'h1, 0, 1, 1, 6'b000001, 1, 2, 2);
    issue(M_OR, 64'h1, 0, 1, 1, 6'b000001, 1, 3, 3);
    issue(M_OR, 64'h1, 0, 1, 1, 6'b000001, 1, 1, 1);
    issue(M_OR, 64'h0, 1, 1, 0, 6'b000000, 1, 1, 1);
    idle(0); drain();

    // 5: saturation of the 2-bit counter
    idle(1);
    for (int i = 1; i <= 6; i++)
      issue(M_OR, 64'h1, 0, 1, 1, 6'b000001, 1, 16'(i), (i > 3) ? 2'd3 : 2'(i));
    idle(0); drain();

    // 6: reset while vectors are in flight
    issue(M_OR, 64'h1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 64'h1; in_mode = M_AND;
    issue(M_OR, 64'h0, 0, 1, 0, 6'b000000, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    idle(0); drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
